// File: rtl/aes_pkg.sv
// aes_pkg: round count, Rcon table, FSM state type and the linear round-function
// helpers (xtime, MixColumns on one column, ShiftRows) for the iterative AES-128 core.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // 2a^3b == xtime(a^b)^b, which keeps each output byte to one xtime
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        mix_column = {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
                      xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3,
                      xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3,
                      xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        shift_rows = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, previous round key to next round key.
module aes_key_step (
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox u_sbox (.x(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box, computed as the GF(2^8) inverse (a^254) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, t, inv;

    always_comb begin
        x2  = gmul(x, x);
        x3  = gmul(x2, x);
        x12 = gmul(gmul(x3, x3), gmul(x3, x3));
        x15 = gmul(x12, x3);
        t   = gmul(x15, x15);
        t   = gmul(t, t);
        t   = gmul(t, t);
        t   = gmul(t, t);
        inv = gmul(gmul(t, x12), x2);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/subBytes.sv
// subBytes: byte-wise S-box substitution over the 128-bit state.
module subBytes (
    input  logic [127:0] a,
    output logic [127:0] y
);

    for (genvar i = 0; i < 16; i++) begin : g_sb
        sbox u_sbox (.x(a[8*i +: 8]), .y(y[8*i +: 8]));
    end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption, one round per clock, valid/ready on both sides.
// Optional abort port when AES_ABORT_EN is defined.
module aes128_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);
    import aes_pkg::*;

    if (NR != aes_pkg::NR) begin : g_nr_check
        $error("aes128_encrypt_iter: only NR=10 (AES-128) is supported");
    end

    state_t       fsm, fsm_d;
    logic [127:0] state, state_d, rk, rk_d, ct, ct_d;
    logic [127:0] sb, sr, mc, rk_next;
    logic [3:0]   rnd, rnd_d;
    logic         last, abort_i;

`ifdef AES_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    subBytes     u_sub (.a(state), .y(sb));
    aes_key_step u_key (.rk_in(rk), .rcon(rcon(rnd)), .rk_out(rk_next));

    assign sr = shift_rows(sb);
    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign last       = (rnd == 4'(NR));
    assign in_ready   = (fsm == IDLE) && !abort_i;
    assign busy       = (fsm == ROUND);
    assign out_valid  = (fsm == DONE);
    assign ciphertext = ct;

    always_comb begin
        fsm_d   = fsm;
        state_d = state;
        rk_d    = rk;
        rnd_d   = rnd;
        ct_d    = ct;
        case (fsm)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = (last ? sr : mc) ^ rk_next;
                rk_d    = rk_next;
                if (last) begin
                    ct_d  = sr ^ rk_next;
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    rnd_d = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // abort discards the block in flight but keeps the last delivered ciphertext
        if (abort_i && fsm != IDLE) begin
            fsm_d = IDLE;
            rnd_d = '0;
            ct_d  = ct;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            rk    <= '0;
            rnd   <= '0;
            ct    <= '0;
        end else begin
            fsm   <= fsm_d;
            state <= state_d;
            rk    <= rk_d;
            rnd   <= rnd_d;
            ct    <= ct_d;
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: byte-array AES reference plus a transaction-level timing model,
// checked every cycle, with FIPS-197 vectors, back-pressure, back-to-back, reset and abort cases.
module tb_aes128_encrypt_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] key = '0, plaintext = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext;
`ifdef AES_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0, errors = 0, cyc = 0;

    // model: age = edges since accept (-1 when idle), ct held, queues of accepts/deliveries
    int           age = -1;
    logic [127:0] cur_ct = '0, pend_ct = '0, junk;
    logic         ab;
    int           acc_cyc[$];
    logic [127:0] done_q[$];

    always #5 clk = ~clk;

    aes128_encrypt_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .plaintext(plaintext), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext),
`ifdef AES_ABORT_EN
        .abort(abort),
`endif
        .busy(busy));

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns matrix entry chosen by (col - row) mod 4: 2,3,1,1
    function automatic logic [7:0] gm(input logic [7:0] a, input int d);
        if (d == 0) return xt(a);
        if (d == 1) return xt(a) ^ a;
        return a;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k_in, input logic [127:0] p_in,
                                             output logic [127:0] r1);
        logic [7:0]   s[16], k[16], t[16], x, rc;
        logic [127:0] res;
        rc = 8'h01;
        r1 = '0;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            k[b] = k_in[127-8*b -: 8];
            s[b] = p_in[127-8*b -: 8] ^ k[b];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            k[0] = k[0] ^ SBOX[k[13]] ^ rc;
            k[1] = k[1] ^ SBOX[k[14]];
            k[2] = k[2] ^ SBOX[k[15]];
            k[3] = k[3] ^ SBOX[k[12]];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            for (int i = 0; i < 16; i++) t[i] = SBOX[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    x = 8'h00;
                    for (int j = 0; j < 4; j++) x = x ^ gm(t[4*c+j], (j - r + 4) % 4);
                    s[4*c+r] = (rnd < 10) ? x : t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
            for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
            if (rnd == 1) r1 = res;
            rc = xt(rc);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ab = 1'b0;
`ifdef AES_ABORT_EN
        ab = abort;
`endif
        if (rst) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_ciphertext", ciphertext, '0);
            age    = -1;
            cur_ct = '0;
        end else begin
            check("in_ready", in_ready, (age < 0 && !ab));
            check("busy", busy, (age >= 0 && age < 10));
            check("out_valid", out_valid, (age >= 10));
            check("ciphertext", ciphertext, cur_ct);
            if (age < 0) begin
                if (in_valid && !ab) begin
                    age = 0;
                    pend_ct = aes_ref(key, plaintext, junk);
                    acc_cyc.push_back(cyc);
                end
            end else if (ab) begin
                age = -1;
            end else if (age < 10) begin
                age++;
                if (age == 10) cur_ct = pend_ct;
            end else if (out_ready) begin
                done_q.push_back(ciphertext);
                age = -1;
            end
        end
    end

    task automatic send(input logic [127:0] k, input logic [127:0] p);
        int n;
        n = 0;
        key = k;
        plaintext = p;
        in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (age != 0 && n < 40);
        in_valid = 1'b0;
        check("accept_in_time", (n < 40), 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_in_time", out_valid, 1);
    endtask

    task automatic take(input string name, input logic [127:0] exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_delivered"}, done_q.size(), 1);
        if (done_q.size() > 0) check(name, done_q.pop_front(), exp);
        done_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        logic [127:0] r1;

        check("model_c1", aes_ref(C1_KEY, C1_PT, r1), C1_CT);
        check("model_b", aes_ref(B_KEY, B_PT, r1), B_CT);
        check("model_b_round1", r1, B_R1);

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_ct", ciphertext, '0);

        // FIPS-197 C.1 with latency
        send(C1_KEY, C1_PT);
        wait_valid(n);
        check("c1_latency", n, 10);
        take("c1_ct", C1_CT);

        // FIPS-197 App. B with round-1 probe
        send(B_KEY, B_PT);
        @(posedge clk); #1;
        check("b_round1_state", dut.state, B_R1);
        wait_valid(n);
        take("b_ct", B_CT);

        // back-pressure with input noise
        send(C1_KEY, C1_PT);
        wait_valid(n);
        base = acc_cyc.size();
        for (int i = 0; i < 20; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom % 2);
            @(posedge clk); #1;
            check("bp_ct_stable", ciphertext, C1_CT);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("bp_no_accept", acc_cyc.size(), base);
        take("bp_ct", C1_CT);
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);

        // back-to-back with in_valid held
        base = acc_cyc.size();
        out_ready = 1'b1;
        key = C1_KEY; plaintext = C1_PT; in_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < base + 2 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (acc_cyc.size() == base + 1) begin key = B_KEY; plaintext = B_PT; end
        end
        in_valid = 1'b0;
        n = 0;
        while (done_q.size() < 2 && n < 60) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        check("b2b_count", done_q.size(), 2);
        if (acc_cyc.size() >= base + 2) check("b2b_interval", acc_cyc[base+1] - acc_cyc[base], 12);
        if (done_q.size() >= 2) begin
            check("b2b_first", done_q[0], C1_CT);
            check("b2b_second", done_q[1], B_CT);
        end
        done_q.delete();

        // randomized blocks, gaps and out_ready stalls
        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            key = {$urandom, $urandom, $urandom, $urandom};
            n = 0;
            while (done_q.size() == 0 && n < 80) begin
                out_ready = 1'($urandom % 2);
                @(posedge clk); #1;
                n++;
            end
            out_ready = 1'b0;
            check("rand_delivered", done_q.size(), 1);
            done_q.delete();
        end

        // asynchronous reset during round 5
        send(C1_KEY, C1_PT);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_ct", ciphertext, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(C1_KEY, C1_PT);
        wait_valid(n);
        check("post_rst_latency", n, 10);
        take("post_rst_ct", C1_CT);

`ifdef AES_ABORT_EN
        send(B_KEY, B_PT);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_ct_kept", ciphertext, C1_CT);
        repeat (15) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        base = acc_cyc.size();
        abort = 1'b1; in_valid = 1'b1; key = C1_KEY; plaintext = C1_PT;
        #1 check("abort_blocks_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check("abort_blocks_accept", acc_cyc.size(), base);
        send(B_KEY, B_PT);
        wait_valid(n);
        take("post_abort_ct", B_CT);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption core, one round per clock.
- Owns the 128-bit state register and round controller that feed the existing `subBytes` stage and consume its output.
- Applies ShiftRows, MixColumns and AddRoundKey, and expands the round key on the fly.
- Valid/ready handshake on both the input and output sides.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; other values are unsupported and must be rejected by an elaboration check.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  key/plaintext offered
- in_ready  output  1  core can accept a block
- key  input  128  cipher key; byte 0 = bits [127:120] (FIPS-197 order)
- plaintext  input  128  input block; same byte order as key
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result; same byte order
- busy  output  1  high while rounds are in progress

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, ciphertext=0, state=0, round key=0, round counter=0.
- Byte/column mapping: state byte b sits at bits [127-8b -: 8]. Column c = bytes 4c..4c+3, where byte 4c is the top row.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: state<=plaintext^key, rk<=key, rnd<=1, go to ROUND.
  - ROUND: in_ready=0, busy=1. Each cycle:
    - rk_next = KeyExpand(rk, Rcon[rnd]).
    - state <= MixColumns(ShiftRows(subBytes(state))) ^ rk_next; MixColumns is skipped when rnd==NR.
    - rk<=rk_next, rnd<=rnd+1.
    - When rnd==NR: latch ciphertext, out_valid<=1, go to DONE.
  - DONE: out_valid=1, busy=0, in_ready=0. ciphertext stays stable until out_valid&out_ready, then out_valid<=0 and go to IDLE.
- Latency: accept edge at T; round edges at T+1..T+10; out_valid is high from the cycle after edge T+10.
  - Minimum issue interval is 12 cycles (accept, 10 rounds, 1 DONE cycle with out_ready=1).
- Input capture: key and plaintext are sampled only on the accept edge. Input changes during ROUND/DONE are ignored.
- Round key:
  - KeyExpand: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; wi' = wi ^ w(i-1)'.
  - Rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
- Counter: rnd is 4 bits, never exceeds NR, and is cleared on entry to IDLE.
- out_ready held high before completion has no effect; it is only sampled in DONE.
- in_valid asserted in ROUND/DONE is not accepted and causes no state change.
- Reset mid-operation: immediately returns to reset values. The partial result is discarded and out_valid never glitches high.

Optional Feature:
Macro `AES_ABORT_EN`.
- Defined: adds port abort (input, 1). abort=1 in ROUND or DONE returns to IDLE on the next edge with out_valid<=0, ciphertext unchanged and rnd cleared. abort in IDLE blocks acceptance that cycle (in_ready=0 while abort=1).
- Undefined: no abort port and no associated logic.

Decomposition:
- Package `aes_pkg`:
  - NR, the Rcon table (function rcon(rnd)).
  - Functions xtime, mix_column(32b), shift_rows(128b).
  - FSM state typedef {IDLE, ROUND, DONE}.
- Sub-module `aes_key_step` (combinational):
  - Ports rk_in[127:0], rcon[7:0], rk_out[127:0].
  - Instantiates 4 sbox for SubWord.
- The core instantiates the existing `subBytes` for the state path.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff.
  - Response: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
- FIPS-197 App. B:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734.
  - Response: ct=3925841d02dc09fbdc118597196a0b32. Probe after round 1: state=a49c7ff2689f352b6b5bea43026a5049.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles, change key/plaintext and pulse in_valid meanwhile.
  - Response: ciphertext stable, in_ready=0, no second accept. Then out_ready=1 gives one-cycle handshake, in_ready=1 next cycle.
- Back-to-back blocks:
  - Stimulus: C.1 then App. B with in_valid held high and out_ready=1.
  - Response: both correct results in order, accepts 12 cycles apart.
- Reset mid-round:
  - Stimulus: assert rst asynchronously at round 5.
  - Response: outputs at reset values immediately. A subsequent C.1 run is still correct.
- Abort (`AES_ABORT_EN`):
  - Stimulus: abort at round 3.
  - Response: IDLE next edge, out_valid never asserts. The next run gives the correct ciphertext.
